// File: rtl/change_arb_if.sv
// Handshake bundle between payout requesters, the arbiter and the change dispenser.
// The arbiter attaches through the slave modport.
interface change_arb_if #(
  parameter int NREQ  = 3,
  parameter int AMT_W = 10
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AMT_W-1:0] req_amount;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       done;
  logic                  disp_go;
  logic [AMT_W-1:0]      disp_change;
  logic                  disp_done;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  timeout_err;

  modport master (
    output req, req_amount, disp_done,
    input  ack, done, disp_go, disp_change,
    input  busy, grant_id, timeout_err
  );

  modport slave (
    input  req, req_amount, disp_done,
    output ack, done, disp_go, disp_change,
    output busy, grant_id, timeout_err
  );
endinterface

// File: rtl/change_dispense_arbiter.sv
// Round-robin arbiter sharing one change dispenser between payout requesters.
// Optional WAIT watchdog enabled by defining CHANGE_ARB_TIMEOUT_EN.
module change_dispense_arbiter #(
  parameter int NREQ           = 3,
  parameter int AMT_W          = 10,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic         clk,
  input logic         reset,
  change_arb_if.slave bus
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("change_dispense_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_WAIT, S_GAP
  } state_t;

  state_t           state_q;
  logic [NREQ-1:0]  ack_q;
  logic [NREQ-1:0]  done_q;
  logic             go_q;
  logic [AMT_W-1:0] chg_q;
  logic             busy_q;
  logic [1:0]       grant_q;
  logic [1:0]       rr_q;
  logic [GW-1:0]    gap_q;

  logic             pick_vld_d;
  logic [1:0]       pick_d;
  logic [AMT_W-1:0] amt_d;
  logic [1:0]       rr_d;
  logic             tmo_hit;
  logic             fin_d;

  // First asserted request at or after the rr pointer, wrapping mod NREQ
  always_comb begin
    logic [2:0] j;
    j          = '0;
    pick_vld_d = 1'b0;
    pick_d     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = 3'(rr_q) + 3'(k);
      if (j >= 3'(NREQ)) j = j - 3'(NREQ);
      if (bus.req[j[1:0]]) begin
        pick_vld_d = 1'b1;
        pick_d     = j[1:0];
      end
    end
    amt_d = bus.req_amount[int'(pick_d)*AMT_W +: AMT_W];
  end

  assign rr_d = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;

`ifdef CHANGE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          terr_q;

  assign tmo_hit = (state_q == S_WAIT) && !bus.disp_done &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == S_LOAD) tmo_q <= '0;
      else if (state_q == S_WAIT) tmo_q <= tmo_q + TW'(1);
      if (tmo_hit) terr_q <= 1'b1;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Payout ends: zero amount leaves LOAD, or WAIT sees completion/timeout
  assign fin_d = ((state_q == S_LOAD) && (chg_q == '0)) ||
                 ((state_q == S_WAIT) && (bus.disp_done || tmo_hit));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      done_q  <= '0;
      go_q    <= 1'b0;
      chg_q   <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      go_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            grant_q        <= pick_d;
            chg_q          <= amt_d;
            ack_q[pick_d]  <= 1'b1;
            go_q           <= |amt_d;
            busy_q         <= 1'b1;
            state_q        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (chg_q != '0) state_q <= S_WAIT;
        end
        S_WAIT: ;
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (fin_d) begin
        done_q[grant_q] <= 1'b1;
        rr_q            <= rr_d;
        gap_q           <= '0;
        if (GAP_CYCLES == 0) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else begin
          state_q <= S_GAP;
        end
      end
    end
  end

  assign bus.ack         = ack_q;
  assign bus.done        = done_q;
  assign bus.disp_go     = go_q;
  assign bus.disp_change = chg_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;

endmodule

// File: tb/tb_change_dispense_arbiter.sv
// Directed bench for change_dispense_arbiter (NREQ=3, GAP_CYCLES=4).
// Timeout scenario runs only when CHANGE_ARB_TIMEOUT_EN is defined.
module tb_change_dispense_arbiter;

  localparam int NREQ  = 3;
  localparam int AMT_W = 10;
  localparam int GAP   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  change_arb_if #(.NREQ(NREQ), .AMT_W(AMT_W)) bus ();

  change_dispense_arbiter #(
    .NREQ(NREQ),
    .AMT_W(AMT_W),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_amt(input int i, input int a);
    bus.req_amount[i*AMT_W +: AMT_W] = AMT_W'(a);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req       = '0;
    bus.disp_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"},  32'(bus.ack), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_go"},   32'(bus.disp_go), 0);
    check({tag, "_chg"},  32'(bus.disp_change), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_gid"},  32'(bus.grant_id), 0);
    check({tag, "_terr"}, 32'(bus.timeout_err), 0);
  endtask

  // Wait for ack of idx, run the dispenser handshake, check done and gap
  task automatic serve(input int idx, input int amt, input int dly,
                       input bit chk_spacing);
    int n;
    n = 0;
    while (bus.ack == '0 && n < 20) begin
      tick();
      n++;
    end
    if (bus.ack == '0) begin
      check("ack_timeout", 0, 1);
      return;
    end
    if (chk_spacing) check("done_to_ack", 32'(cyc - last_done), GAP + 1);
    check("ack",     32'(bus.ack), 32'(1) << idx);
    check("gid",     32'(bus.grant_id), 32'(idx));
    check("chg",     32'(bus.disp_change), 32'(amt));
    check("go",      32'(bus.disp_go), (amt != 0) ? 1 : 0);
    check("busy_ld", 32'(bus.busy), 1);
    bus.req[idx] = 1'b0;
    if (amt != 0) begin
      tick();
      check("go_pulse", 32'(bus.disp_go), 0);
      check("chg_hold", 32'(bus.disp_change), 32'(amt));
      check("ack_pulse", 32'(bus.ack), 0);
      repeat (dly - 2) tick();
      check("no_early_done", 32'(bus.done), 0);
      bus.disp_done = 1'b1;
      tick();
      bus.disp_done = 1'b0;
    end else begin
      tick();
      check("zero_nogo", 32'(bus.disp_go), 0);
    end
    check("done", 32'(bus.done), 32'(1) << idx);
    last_done = cyc;
    tick();
    check("done_pulse", 32'(bus.done), 0);
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    check("busy_low", 32'(bus.busy), 0);
    check("gap_len", 32'(cyc - last_done), GAP);
  endtask

  initial begin
    bus.req        = '0;
    bus.req_amount = '0;
    bus.disp_done  = 1'b0;
    do_reset();
    check_idle("rst");

    set_amt(0, 35);
    bus.req = 3'b001;
    serve(0, 35, 6, 1'b0);

    do_reset();
    set_amt(0, 5);
    set_amt(1, 10);
    set_amt(2, 25);
    bus.req = 3'b111;
    serve(0, 5, 3, 1'b0);
    serve(1, 10, 4, 1'b1);
    serve(2, 25, 2, 1'b1);

    set_amt(1, 12);
    bus.req = 3'b010;
    serve(1, 12, 3, 1'b0);
    set_amt(0, 8);
    bus.req = 3'b011;
    serve(0, 8, 3, 1'b0);
    serve(1, 12, 3, 1'b1);

    set_amt(2, 0);
    bus.req = 3'b100;
    serve(2, 0, 0, 1'b0);

    set_amt(0, 7);
    bus.req = 3'b001;
    tick();
    check("t5_ack", 32'(bus.ack), 1);
    bus.req = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("t5_rst");
    bus.disp_done = 1'b1;
    tick();
    bus.disp_done = 1'b0;
    check("t5_nodone", 32'(bus.done), 0);
    tick();
    check("t5_nodone2", 32'(bus.done), 0);
    check("t5_idle", 32'(bus.busy), 0);

`ifdef CHANGE_ARB_TIMEOUT_EN
    set_amt(0, 20);
    bus.req = 3'b001;
    tick();
    check("t6_ack", 32'(bus.ack), 1);
    bus.req = '0;
    repeat (16) tick();
    check("t6_early", 32'(bus.done), 0);
    check("t6_terr0", 32'(bus.timeout_err), 0);
    tick();
    check("t6_done", 32'(bus.done), 1);
    check("t6_terr", 32'(bus.timeout_err), 1);
    repeat (GAP) tick();
    check("t6_idle", 32'(bus.busy), 0);
    set_amt(1, 3);
    bus.req = 3'b010;
    serve(1, 3, 3, 1'b0);
    check("t6_sticky", 32'(bus.timeout_err), 1);
`else
    repeat (30) tick();
    check("terr_tied", 32'(bus.timeout_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
